// File: rtl/fir_da_filter.sv
// 64-tap FIR filter built on bit-serial distributed arithmetic.
// There are eight banks of 256-entry partial-sum LUTs, one per group of 8 taps. Each sample is processed LSB-first over 16 clocks.
module fir_da_filter (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [15:0]  din,
  input  logic                valid_in,
  input  logic signed [19:0]  CIN,
  input  logic        [10:0]  CADDR,
  input  logic                CLOAD,
  output logic signed [38:0]  dout,
  output logic                valid_out
);

  localparam int unsigned DIN_W  = 16;
  localparam int unsigned LUT_W  = 20;
  localparam int unsigned NGRP   = 8;
  localparam int unsigned GRP_SZ = 8;
  localparam int unsigned NTAP   = NGRP * GRP_SZ;
  localparam int unsigned SUM_W  = LUT_W + 3;
  localparam int unsigned DOUT_W = SUM_W + DIN_W;
  localparam int unsigned K_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  logic        [K_W-1:0]     r_k;
  logic signed [DOUT_W-1:0]  r_acc;
  logic signed [DOUT_W-1:0]  r_dout;
  logic                      r_valid_out;
  logic signed [DIN_W-1:0]   r_tap [NTAP];
  logic signed [LUT_W-1:0]   r_lut [NGRP][256];

  logic        [7:0]         w_addr  [NGRP];
  logic signed [LUT_W-1:0]   w_lut_q [NGRP];
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [DOUT_W-1:0]  w_term;

  assign dout      = r_dout;
  assign valid_out = r_valid_out;

  // LUT banks have no reset. The contents survive reset, and any write is visible to the next bit cycle.
  always_ff @(posedge clk) begin
    if (CLOAD) begin
      r_lut[CADDR[10:8]][CADDR[7:0]] <= CIN;
    end
  end

  // Gather bit k of every tap into the group addresses, then sum the eight partial sums.
  always_comb begin
    w_sum = '0;
    for (int g = 0; g < NGRP; g++) begin
      w_addr[g] = '0;
      for (int b = 0; b < GRP_SZ; b++) begin
        w_addr[g][b] = r_tap[g*GRP_SZ + b][r_k];
      end
      w_lut_q[g] = r_lut[g][w_addr[g]];
      w_sum      = w_sum + SUM_W'(w_lut_q[g]);
    end
    w_term = DOUT_W'(w_sum) <<< r_k;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_acc       <= '0;
      r_dout      <= '0;
      r_valid_out <= 1'b0;
      for (int t = 0; t < NTAP; t++) begin
        r_tap[t] <= '0;
      end
    end else begin
      r_valid_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A LUT write takes priority over accepting a sample.
          if (valid_in && !CLOAD) begin
            r_tap[0] <= din;
            for (int t = 1; t < NTAP; t++) begin
              r_tap[t] <= r_tap[t-1];
            end
            r_acc   <= '0;
            r_k     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // The last bit is the two's-complement sign bit, so it carries negative weight.
          if (r_k == K_W'(DIN_W - 1)) begin
            r_acc   <= r_acc - w_term;
            r_state <= S_DONE;
          end else begin
            r_acc <= r_acc + w_term;
            r_k   <= r_k + K_W'(1);
          end
        end
        S_DONE: begin
          r_dout      <= r_acc;
          r_valid_out <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_da_filter.sv
// Directed testbench for fir_da_filter.
// It checks every result against a bench-side convolution model built from the same coefficients loaded into the LUT.
module tb_fir_da_filter;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] din = '0;
  logic               valid_in = 1'b0;
  logic signed [19:0] CIN = '0;
  logic        [10:0] CADDR = '0;
  logic               CLOAD = 1'b0;
  logic signed [38:0] dout;
  logic               valid_out;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     c    [64];
  longint hist [64];

  always #5 clk = ~clk;

  fir_da_filter dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .valid_in  (valid_in),
    .CIN       (CIN),
    .CADDR     (CADDR),
    .CLOAD     (CLOAD),
    .dout      (dout),
    .valid_out (valid_out)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_word(input int addr, input int val);
    @(negedge clk);
    CLOAD = 1'b1;
    CADDR = 11'(addr);
    CIN   = 20'(val);
    @(negedge clk);
    CLOAD = 1'b0;
  endtask

  task automatic load_lut();
    int s;
    for (int g = 0; g < 8; g++) begin
      for (int p = 0; p < 256; p++) begin
        s = 0;
        for (int b = 0; b < 8; b++) begin
          if (((p >> b) & 1) == 1) s += c[8*g + b];
        end
        @(negedge clk);
        CLOAD = 1'b1;
        CADDR = 11'(g*256 + p);
        CIN   = 20'(s);
      end
    end
    @(negedge clk);
    CLOAD = 1'b0;
  endtask

  function automatic longint model();
    longint acc = 0;
    for (int t = 0; t < 64; t++) acc += longint'(c[t]) * hist[t];
    return acc;
  endfunction

  task automatic push(input longint x);
    for (int t = 63; t > 0; t--) hist[t] = hist[t-1];
    hist[0] = x;
  endtask

  task automatic clear_hist();
    for (int t = 0; t < 64; t++) hist[t] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_hist();
  endtask

  // Drive one sample and wait for its result. lat counts clocks from the accepting edge.
  task automatic send(input int x, output longint y, output int lat);
    @(negedge clk);
    din      = 16'(x);
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    push(longint'(x));
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (valid_out) break;
    end
    if (!valid_out) check_eq("valid_out_timeout", longint'(valid_out), 1);
    y = longint'(dout);
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (valid_out) n++;
    end
  endtask

  task automatic rand_coeffs();
    for (int t = 0; t < 64; t++) c[t] = int'($urandom_range(1024)) - 512;
  endtask

  initial begin
    longint y;
    int     lat;
    int     n;
    int     x;
    int     first_lat;
    longint first_y;
    longint exp_y;

    clear_hist();
    // Reset behaviour and quiet idle
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_dout", longint'(dout), 0);
    check_eq("reset_valid_out", longint'(valid_out), 0);
    @(negedge clk);
    reset = 1'b0;
    count_pulses(20, n);
    check_eq("idle_no_valid", longint'(n), 0);

    // Impulse response reproduces the coefficients
    rand_coeffs();
    load_lut();
    do_reset();
    send(1, y, lat);
    check_eq("impulse_c0", y, longint'(c[0]));
    check_eq("impulse_latency", longint'(lat), 17);
    for (int i = 1; i <= 64; i++) begin
      send(0, y, lat);
      check_eq($sformatf("impulse_c%0d", i), y, (i < 64) ? longint'(c[i]) : 0);
    end

    // Full-scale samples with every coefficient at its maximum
    for (int t = 0; t < 64; t++) c[t] = 512;
    load_lut();
    do_reset();
    for (int i = 0; i < 64; i++) send(-32768, y, lat);
    check_eq("extreme_neg", y, -64'sd1073741824);
    for (int i = 0; i < 64; i++) send(32767, y, lat);
    check_eq("extreme_pos", y, 64'sd1073709056);

    // Random stream against the golden convolution
    rand_coeffs();
    load_lut();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      x = int'($urandom_range(1023));
      send(x, y, lat);
      check_eq($sformatf("stream_y%0d", i), y, model());
      check_eq($sformatf("stream_lat%0d", i), longint'(lat), 17);
      repeat (174) @(posedge clk);
    end

    // A second strobe while the filter is busy is dropped
    @(negedge clk);
    din      = 16'sd7;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    push(7);
    exp_y = model();
    repeat (4) @(posedge clk);
    @(negedge clk);
    din      = 16'sd999;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    n = 0;
    first_lat = 0;
    first_y = 0;
    for (int cyc = 6; cyc < 46; cyc++) begin
      @(posedge clk);
      #1;
      if (valid_out) begin
        if (n == 0) begin
          first_lat = cyc;
          first_y   = longint'(dout);
        end
        n++;
      end
    end
    check_eq("busy_pulses", longint'(n), 1);
    check_eq("busy_latency", longint'(first_lat), 17);
    check_eq("busy_y", first_y, exp_y);
    send(3, y, lat);
    check_eq("busy_next_y", y, model());

    // A LUT write wins over valid_in, and the written word is used
    do_reset();
    @(negedge clk);
    din      = 16'sd100;
    valid_in = 1'b1;
    CLOAD    = 1'b1;
    CADDR    = 11'd1;
    CIN      = 20'sd12345;
    @(negedge clk);
    valid_in = 1'b0;
    CLOAD    = 1'b0;
    count_pulses(25, n);
    check_eq("cload_no_valid", longint'(n), 0);
    send(1, y, lat);
    check_eq("cload_word_used", y, 12345);
    write_word(1, c[0]);

    // Reset in the middle of a computation aborts it and leaves the LUT intact
    do_reset();
    @(negedge clk);
    din      = 16'sd1;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_hist();
    count_pulses(25, n);
    check_eq("midrun_no_valid", longint'(n), 0);
    check_eq("midrun_dout", longint'(dout), 0);
    send(1, y, lat);
    check_eq("midrun_impulse_c0", y, longint'(c[0]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
